// File: rtl/operand_stream_buffer.sv
`default_nettype none
// ============================================================================
// Module   : operand_stream_buffer
// Brief    : Buffers W and X from a serial element stream and replays them as
//            outer-product beats (W column k, X row k) to a DIM_MAX-lane MAC.
// Revision : 1.0 - initial release
// ============================================================================
module operand_stream_buffer #(
    parameter int DATA_W  = 4,
    parameter int DIM_MAX = 3,
    parameter int DIM_BW  = $clog2(DIM_MAX + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      cfg_start,
    input  logic [DIM_BW-1:0]         cfg_rows_w,
    input  logic [DIM_BW-1:0]         cfg_cols_w,
    input  logic [DIM_BW-1:0]         cfg_rows_x,
    input  logic [DIM_BW-1:0]         cfg_cols_x,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIM_MAX*DATA_W-1:0] out_w,
    output logic [DIM_MAX*DATA_W-1:0] out_x,
    output logic                      out_last,
    output logic                      mac_clear,
    output logic                      busy,
    output logic                      done,
    output logic                      cfg_err
);

    localparam int                c_addr_w  = (DIM_MAX > 1) ? $clog2(DIM_MAX * DIM_MAX) : 1;
    localparam int                c_depth   = DIM_MAX * DIM_MAX;
    localparam logic [DIM_BW-1:0] c_dim_max = DIM_BW'(DIM_MAX);
    localparam logic [DIM_BW-1:0] c_one     = DIM_BW'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_LOAD_X = 3'd2,
        S_CLR    = 3'd3,
        S_STREAM = 3'd4
    } state_t;

    state_t              r_state, w_state_nxt;
    logic [DIM_BW-1:0]   r_row, w_row_nxt;
    logic [DIM_BW-1:0]   r_col, w_col_nxt;
    logic [DIM_BW-1:0]   r_k, w_k_nxt;
    logic [DIM_BW-1:0]   r_rows_w, w_rows_w_nxt;
    logic [DIM_BW-1:0]   r_cols_w, w_cols_w_nxt;
    logic [DIM_BW-1:0]   r_cols_x, w_cols_x_nxt;
    logic                r_cfg_err, w_cfg_err_nxt;
    logic                r_done, w_done_nxt;

    logic [DATA_W-1:0]   r_w_mem [c_depth];
    logic [DATA_W-1:0]   r_x_mem [c_depth];

    logic                w_cfg_bad;
    logic [DIM_BW-1:0]   w_row_lim;
    logic [DIM_BW-1:0]   w_col_lim;
    logic                w_row_last;
    logic                w_col_last;
    logic                w_k_last;
    logic                w_streaming;
    logic                w_wr_w;
    logic                w_wr_x;
    logic [c_addr_w-1:0] w_wr_addr;

    assign w_cfg_bad = (cfg_rows_w == '0) || (cfg_cols_w == '0) ||
                       (cfg_rows_x == '0) || (cfg_cols_x == '0) ||
                       (cfg_rows_w > c_dim_max) || (cfg_cols_w > c_dim_max) ||
                       (cfg_rows_x > c_dim_max) || (cfg_cols_x > c_dim_max) ||
                       (cfg_rows_x != cfg_cols_w);

    // X is cols_w x cols_x, so the load limits swap between the two phases
    assign w_row_lim  = (r_state == S_LOAD_W) ? r_rows_w : r_cols_w;
    assign w_col_lim  = (r_state == S_LOAD_W) ? r_cols_w : r_cols_x;
    assign w_row_last = (r_row == w_row_lim - c_one);
    assign w_col_last = (r_col == w_col_lim - c_one);
    assign w_k_last   = (r_k == r_cols_w - c_one);

    assign w_streaming = (r_state == S_STREAM);
    assign in_ready    = (r_state == S_LOAD_W) || (r_state == S_LOAD_X);
    assign out_valid   = w_streaming;
    assign out_last    = w_streaming && w_k_last;
    assign mac_clear   = (r_state == S_CLR);
    assign busy        = (r_state != S_IDLE);
    assign done        = r_done;
    assign cfg_err     = r_cfg_err;

    assign w_wr_w    = (r_state == S_LOAD_W) && in_valid;
    assign w_wr_x    = (r_state == S_LOAD_X) && in_valid;
    assign w_wr_addr = c_addr_w'(r_row) * c_addr_w'(DIM_MAX) + c_addr_w'(r_col);

    always_comb begin
        w_state_nxt   = r_state;
        w_row_nxt     = r_row;
        w_col_nxt     = r_col;
        w_k_nxt       = r_k;
        w_rows_w_nxt  = r_rows_w;
        w_cols_w_nxt  = r_cols_w;
        w_cols_x_nxt  = r_cols_x;
        w_cfg_err_nxt = r_cfg_err;
        w_done_nxt    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cfg_start) begin
                    if (w_cfg_bad) begin
                        w_cfg_err_nxt = 1'b1;
                    end else begin
                        w_cfg_err_nxt = 1'b0;
                        w_rows_w_nxt  = cfg_rows_w;
                        w_cols_w_nxt  = cfg_cols_w;
                        w_cols_x_nxt  = cfg_cols_x;
                        w_row_nxt     = '0;
                        w_col_nxt     = '0;
                        w_state_nxt   = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W, S_LOAD_X: begin
                if (in_valid) begin
                    if (w_col_last) begin
                        w_col_nxt = '0;
                        if (w_row_last) begin
                            w_row_nxt   = '0;
                            w_state_nxt = (r_state == S_LOAD_W) ? S_LOAD_X : S_CLR;
                        end else begin
                            w_row_nxt = r_row + c_one;
                        end
                    end else begin
                        w_col_nxt = r_col + c_one;
                    end
                end
            end
            S_CLR: begin
                w_k_nxt     = '0;
                w_state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (out_ready) begin
                    if (w_k_last) begin
                        w_k_nxt     = '0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_k_nxt = r_k + c_one;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_row     <= '0;
            r_col     <= '0;
            r_k       <= '0;
            r_rows_w  <= '0;
            r_cols_w  <= '0;
            r_cols_x  <= '0;
            r_cfg_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_k       <= w_k_nxt;
            r_rows_w  <= w_rows_w_nxt;
            r_cols_w  <= w_cols_w_nxt;
            r_cols_x  <= w_cols_x_nxt;
            r_cfg_err <= w_cfg_err_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Operand storage carries no reset; lanes are gated so stale data never escapes
    always_ff @(posedge clk) begin
        if (w_wr_w) begin
            r_w_mem[w_wr_addr] <= in_data;
        end
        if (w_wr_x) begin
            r_x_mem[w_wr_addr] <= in_data;
        end
    end

    for (genvar i = 0; i < DIM_MAX; i++) begin : g_lane
        localparam logic [c_addr_w-1:0] c_lane     = c_addr_w'(i);
        localparam logic [DIM_BW-1:0]   c_lane_dim = DIM_BW'(i);
        logic                w_w_en;
        logic                w_x_en;
        logic [c_addr_w-1:0] w_w_addr;
        logic [c_addr_w-1:0] w_x_addr;

        assign w_w_en   = w_streaming && (c_lane_dim < r_rows_w);
        assign w_x_en   = w_streaming && (c_lane_dim < r_cols_x);
        assign w_w_addr = w_w_en ? (c_lane * c_addr_w'(DIM_MAX) + c_addr_w'(r_k)) : '0;
        assign w_x_addr = w_x_en ? (c_addr_w'(r_k) * c_addr_w'(DIM_MAX) + c_lane) : '0;
        assign out_w[i*DATA_W +: DATA_W] = w_w_en ? r_w_mem[w_w_addr] : '0;
        assign out_x[i*DATA_W +: DATA_W] = w_x_en ? r_x_mem[w_x_addr] : '0;
    end

endmodule
`default_nettype wire
